ugt_sort_sequencer: RTL and testbench
=====================================

# ugt_sort_sequencer

Sequential sorter that time-shares a single WIDTH-bit unsigned greater-than comparator to sort a block of N samples in ascending order. It sits between a sample source and a consumer on the icestick fabric. It loads N samples over a valid/ready port, then runs an in-place bubble sort with early exit, one comparison per clock. Finally it streams the sorted samples out over a second valid/ready port.

## Interface
Parameters:
- N, 4, number of entries per block; legal range 2..16.
- WIDTH, 8, sample width in bits; the comparator is an unsigned WIDTH-bit greater-than.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- I_DATA  input  WIDTH  input sample.
- I_VALID  input  1  I_DATA is valid.
- I_READY  output  1  block accepts a sample; high only in LOAD.
- O_DATA  output  WIDTH  sorted output sample.
- O_VALID  output  1  O_DATA is valid; high only in DRAIN.
- O_READY  input  1  consumer accepts O_DATA.
- BUSY  output  1  high only in SORT.

## Operation
- Storage: N registers mem[0..N-1], each WIDTH bits. Exactly one comparator instance: gt = mem[j] UGT mem[j+1].
- FSM states: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD:
  - I_READY=1.
  - On I_VALID && I_READY, write mem[wr_idx] <= I_DATA, then wr_idx++.
  - On accepting the N-th sample: wr_idx<=0, p<=0, j<=0, swapped<=0, go to SORT.
- SORT (one comparison per cycle):
  - If gt: swap mem[j] and mem[j+1], and set swapped.
  - Equal values are never swapped, so the sort is stable.
  - If j < N-2-p: j++.
  - Otherwise the pass ends:
    - If no swap occurred in this pass (including the current cycle), or p == N-2: go to DRAIN with rd_idx<=0.
    - Else: p++, j<=0, swapped<=0.
- DRAIN:
  - O_VALID=1, O_DATA=mem[rd_idx].
  - On O_VALID && O_READY: rd_idx++.
  - On the N-th handshake: rd_idx<=0, go to LOAD.
- I_VALID is ignored outside LOAD. O_READY is ignored outside DRAIN.
- Comparisons are unsigned: mem value 8'hFF sorts above 8'h00.
- Counter widths are sized for N. No wrap occurs, because every counter is reset at its terminal value.

## Timing
- Reset values: I_READY=1, O_VALID=0, BUSY=0, O_DATA=0. All mem entries, wr_idx, rd_idx, p, j and swapped are 0.
- RESET asserted in any state, including mid-SORT or mid-DRAIN:
  - Next cycle is LOAD with all state cleared.
  - Partially loaded or partially drained data is discarded.
- The FSM output decode is registered-state based: I_READY, O_VALID and BUSY depend only on the current state. No combinational path from I_VALID to O_VALID, or from O_READY to I_READY.
- The accept edge of the N-th input is edge t:
  - BUSY=1 from cycle t+1.
  - Sort takes C cycles, where N-1 ≤ C ≤ N(N-1)/2. For N=4, C is 3 to 6.
  - O_VALID=1 from cycle t+1+C.
- O_DATA stays stable while O_VALID && !O_READY.
- Back-to-back blocks: I_READY rises the cycle after the final output handshake. There is no dead cycle beyond that.
- Throughput for N=4 with no stalls: 4 load + C sort + 4 drain cycles.

## Test plan
- Reverse input, N=4: load 4,3,2,1 with I_VALID held high. Require BUSY for exactly 6 cycles, then outputs 1,2,3,4 on 4 consecutive cycles with O_READY=1.
- Presorted input: load 10,20,30,40. Require BUSY for exactly 3 cycles (single pass, no swaps, early exit), then outputs 10,20,30,40.
- Unsigned extremes and duplicates: load 8'hFF,8'h00,8'h80,8'h00. Require output 00,00,80,FF, and BUSY no longer than 6 cycles.
- Handshake stalls:
  - Insert I_VALID gaps during LOAD.
  - Toggle O_READY 1,0,0,1,... during DRAIN.
  - Require each sample to be accepted exactly once, O_DATA held during stalls, and I_READY=0 until the 4th output is taken.
- Reset mid-operation:
  - Assert RESET in the 2nd SORT cycle of block 5,1,4,2. Require I_READY=1, BUSY=0 and O_VALID=0 on the next cycle.
  - Then load 9,8,7,6. Require output 6,7,8,9 with no stale data.
- Back-to-back blocks: load and drain 3,1,2,0, then immediately 7,7,7,7. Require 0,1,2,3 followed by 7,7,7,7, with BUSY for 3 cycles on the second block.

Source files
------------

// File: rtl/ugt_sort_sequencer.sv
// ugt_sort_sequencer
//   Collects a block of N unsigned samples and sorts them in ascending order.
//   The sort is an in-place bubble sort with early exit. It uses one WIDTH-bit
//   unsigned greater-than comparator, shared over time at one comparison per
//   clock. The sorted block is then streamed out.
//
// Ports
//   CLK      in   rising-edge clock for all state
//   RESET    in   synchronous active-high reset; returns to LOAD with all state cleared
//   I_DATA   in   WIDTH-bit input sample
//   I_VALID  in   I_DATA valid (only looked at in LOAD)
//   I_READY  out  high only in LOAD
//   O_DATA   out  WIDTH-bit sorted sample, mem[rd_idx]
//   O_VALID  out  high only in DRAIN
//   O_READY  in   consumer accepts O_DATA (only looked at in DRAIN)
//   BUSY     out  high only in SORT
module ugt_sort_sequencer #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I_DATA,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             BUSY
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] mem [N];
  logic [IDX_W-1:0] wr_idx, rd_idx, p, j;
  logic             swapped;

  logic [IDX_W-1:0] j_plus1;
  logic [IDX_W-1:0] last_j;
  logic             gt;
  logic             end_of_pass;
  logic             swapped_now;
  logic             sort_done;

  // The single shared comparator. Pass p only walks j up to N-2-p, because
  // the top p entries are already in their final places.
  assign j_plus1     = j + 1'b1;
  assign last_j      = LAST_PASS - p;
  assign gt          = mem[j] > mem[j_plus1];
  assign end_of_pass = (j == last_j);
  assign swapped_now = swapped | gt;
  assign sort_done   = end_of_pass && (!swapped_now || (p == LAST_PASS));

  assign O_DATA = mem[rd_idx];

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= LOAD;
    else       state <= next_state;
  end

  // Next-state logic. The handshake outputs decode the current state only,
  // so no combinational path exists from I_VALID or O_READY to any output.
  always_comb begin
    next_state = state;
    I_READY    = 1'b0;
    O_VALID    = 1'b0;
    BUSY       = 1'b0;
    case (state)
      LOAD: begin
        I_READY = 1'b1;
        if (I_VALID && (wr_idx == LAST_IDX)) next_state = SORT;
      end
      SORT: begin
        BUSY = 1'b1;
        if (sort_done) next_state = DRAIN;
      end
      DRAIN: begin
        O_VALID = 1'b1;
        if (O_READY && (rd_idx == LAST_IDX)) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  // Datapath: sample storage, load and drain pointers, and pass/position
  // counters. Each counter is cleared at its terminal value rather than
  // allowed to wrap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      p       <= '0;
      j       <= '0;
      swapped <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (I_VALID) begin
            mem[wr_idx] <= I_DATA;
            if (wr_idx == LAST_IDX) begin
              wr_idx  <= '0;
              p       <= '0;
              j       <= '0;
              swapped <= 1'b0;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          // Strict greater-than, so equal neighbours stay put and the sort is stable
          if (gt) begin
            mem[j]       <= mem[j_plus1];
            mem[j_plus1] <= mem[j];
          end
          if (!end_of_pass) begin
            j       <= j_plus1;
            swapped <= swapped_now;
          end else if (sort_done) begin
            rd_idx <= '0;
          end else begin
            p       <= p + 1'b1;
            j       <= '0;
            swapped <= 1'b0;
          end
        end
        DRAIN: begin
          if (O_READY) begin
            if (rd_idx == LAST_IDX) rd_idx <= '0;
            else                    rd_idx <= rd_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ugt_sort_sequencer.sv
// tb_ugt_sort_sequencer
//   Self-checking bench for ugt_sort_sequencer with N=4 and WIDTH=8.
//   Every block is compared against a reference built at array level. The
//   reference gives the ascending result and the number of comparisons that an
//   early-exit bubble sort performs. The bench runs directed cases and then
//   randomized blocks with random input gaps and output stalls.
module tb_ugt_sort_sequencer;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int LIMIT = 200;

  typedef logic [WIDTH-1:0] blk_t [N];

  logic             CLK;
  logic             RESET;
  logic [WIDTH-1:0] I_DATA;
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] O_DATA;
  logic             O_VALID;
  logic             O_READY;
  logic             BUSY;

  int nVectors;
  int nMiscompares;

  ugt_sort_sequencer #(.N(N), .WIDTH(WIDTH)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I_DATA  (I_DATA),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .O_DATA  (O_DATA),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison: counts it, and on a difference reports tag, observed and expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: ascending order plus the cycle count of an early-exit bubble sort
  function automatic void refSort(input blk_t d, output blk_t s, output int cycles);
    logic [WIDTH-1:0] tmp;
    bit sw;
    s = d;
    cycles = 0;
    for (int pass = 0; pass <= N - 2; pass++) begin
      sw = 0;
      for (int k = 0; k <= N - 2 - pass; k++) begin
        cycles++;
        if (s[k] > s[k+1]) begin
          tmp = s[k]; s[k] = s[k+1]; s[k+1] = tmp;
          sw = 1;
        end
      end
      if (!sw) break;
    end
  endfunction

  // Advance one clock. The bench samples and drives 1ns after the rising edge.
  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  // Feed one block. gapMode=1 inserts random I_VALID gaps. On return we are
  // one cycle past the accept edge of the last sample.
  task automatic loadBlock(input blk_t d, input bit gapMode);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < LIMIT) begin
      I_VALID = gapMode ? ($urandom_range(0, 2) != 0) : 1'b1;
      I_DATA  = I_VALID ? d[idx] : WIDTH'($urandom);
      checkOutput("load_i_ready", 32'(I_READY), 32'd1);
      acc = I_VALID && I_READY;
      stepCycle();
      cyc++;
      if (acc) idx++;
    end
    I_VALID = 1'b0;
    checkOutput("load_done_in_time", 32'(idx), 32'(N));
  endtask

  // Load, time the sort, then drain and compare against the reference.
  // stallMode: 0 = O_READY held high, 1 = pattern 1,0,0,1,..., 2 = random.
  task automatic applyStimulus(input string name, input blk_t d, input bit gapMode,
                               input int stallMode);
    blk_t exp;
    int   expCycles;
    int   busyCnt;
    int   k;
    int   cyc;
    bit   take;
    refSort(d, exp, expCycles);
    loadBlock(d, gapMode);
    busyCnt = 0;
    while (BUSY === 1'b1 && busyCnt < LIMIT) begin
      checkOutput({name, "_sort_i_ready"}, 32'(I_READY), 32'd0);
      busyCnt++;
      stepCycle();
    end
    checkOutput({name, "_busy_cycles"}, 32'(busyCnt), 32'(expCycles));
    k = 0;
    cyc = 0;
    while (k < N && cyc < LIMIT) begin
      case (stallMode)
        0:       O_READY = 1'b1;
        1:       O_READY = (cyc % 3 == 0);
        default: O_READY = ($urandom_range(0, 1) == 1);
      endcase
      checkOutput({name, "_o_valid"}, 32'(O_VALID), 32'd1);
      checkOutput({name, "_o_data"}, 32'(O_DATA), 32'(exp[k]));
      checkOutput({name, "_drain_i_ready"}, 32'(I_READY), 32'd0);
      take = O_READY && O_VALID;
      stepCycle();
      cyc++;
      if (take) k++;
    end
    O_READY = 1'b0;
    checkOutput({name, "_drain_done_in_time"}, 32'(k), 32'(N));
    checkOutput({name, "_back_to_load_i_ready"}, 32'(I_READY), 32'd1);
    checkOutput({name, "_back_to_load_o_valid"}, 32'(O_VALID), 32'd0);
  endtask

  initial begin
    blk_t blk;
    nVectors     = 0;
    nMiscompares = 0;
    RESET   = 1'b1;
    I_DATA  = '0;
    I_VALID = 1'b0;
    O_READY = 1'b0;
    repeat (2) stepCycle();
    RESET = 1'b0;

    // Reset state
    checkOutput("reset_i_ready", 32'(I_READY), 32'd1);
    checkOutput("reset_o_valid", 32'(O_VALID), 32'd0);
    checkOutput("reset_busy",    32'(BUSY),    32'd0);
    checkOutput("reset_o_data",  32'(O_DATA),  32'd0);

    // Reverse input: six comparisons, output 1,2,3,4
    blk = '{8'd4, 8'd3, 8'd2, 8'd1};
    applyStimulus("reverse", blk, 1'b0, 0);

    // Presorted input: one pass without swaps
    blk = '{8'd10, 8'd20, 8'd30, 8'd40};
    applyStimulus("presorted", blk, 1'b0, 0);

    // Unsigned extremes and duplicates
    blk = '{8'hFF, 8'h00, 8'h80, 8'h00};
    applyStimulus("extremes", blk, 1'b0, 0);

    // Input gaps and output stall pattern 1,0,0,1
    blk = '{8'd33, 8'd7, 8'd200, 8'd7};
    applyStimulus("stalls", blk, 1'b1, 1);

    // Reset in the second SORT cycle, then a clean block
    blk = '{8'd5, 8'd1, 8'd4, 8'd2};
    loadBlock(blk, 1'b0);
    checkOutput("midsort_busy", 32'(BUSY), 32'd1);
    stepCycle();
    RESET = 1'b1;
    stepCycle();
    RESET = 1'b0;
    checkOutput("after_reset_i_ready", 32'(I_READY), 32'd1);
    checkOutput("after_reset_busy",    32'(BUSY),    32'd0);
    checkOutput("after_reset_o_valid", 32'(O_VALID), 32'd0);
    checkOutput("after_reset_o_data",  32'(O_DATA),  32'd0);
    blk = '{8'd9, 8'd8, 8'd7, 8'd6};
    applyStimulus("post_reset", blk, 1'b0, 0);

    // Back-to-back blocks
    blk = '{8'd3, 8'd1, 8'd2, 8'd0};
    applyStimulus("b2b_first", blk, 1'b0, 0);
    blk = '{8'd7, 8'd7, 8'd7, 8'd7};
    applyStimulus("b2b_second", blk, 1'b0, 0);

    // Randomized blocks. Half of them use a narrow value range to force duplicates.
    for (int r = 0; r < 30; r++) begin
      for (int e = 0; e < N; e++)
        blk[e] = (r % 2 == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3));
      applyStimulus("random", blk, 1'($urandom_range(0, 1)), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
